// File: rtl/mux_bus_arbiter_if.sv
// Handshake bundle between the requesters and the shared-mux select arbiter.
// The arbiter takes the slave view; the requesting side takes the master view.
interface mux_bus_arbiter_if;
    logic       arbEn;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] selCode;
    logic       busValid;
    logic [7:0] busyCnt;

    modport master (
        output arbEn, req,
        input  grant, selCode, busValid, busyCnt
    );

    modport slave (
        input  arbEn, req,
        output grant, selCode, busValid, busyCnt
    );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter that owns the select port of the shared 8:1 datapath mux.
// Ownership is bounded to MAX_BURST beats and followed by one turnaround cycle.
module mux_bus_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst_n,
    mux_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] last_q, last_d;

    logic [2:0] win;
    logic       found;
    logic [2:0] idx;

    // Circular scan starting just after the previous owner, so it ranks last.
    always_comb begin
        win   = last_q;
        found = 1'b0;
        idx   = last_q;
        for (int k = 1; k <= 8; k++) begin
            idx = last_q + 3'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            last_q  <= 3'd7;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, TURN: begin
                if (bus.arbEn && found) state_d = GRANT;
                else                    state_d = IDLE;
            end
            GRANT: begin
                // arbEn is deliberately ignored here: a running burst always completes.
                if (!bus.req[sel_q])         state_d = TURN;
                else if (cnt_q == LAST_BEAT) state_d = TURN;
                else                         state_d = GRANT;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs; selCode only moves on GRANT entry.
    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_d)
            GRANT: begin
                if (state_q != GRANT) begin
                    grant_d = 8'd1 << win;
                    sel_d   = win;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    last_d  = win;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.grant    = grant_q;
    assign bus.selCode  = sel_q;
    assign bus.busValid = valid_q;
    assign bus.busyCnt  = cnt_q;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Directed bench for mux_bus_arbiter: each step drives req/arbEn, queues the
// output expected after the next rising edge, then pops and checks it.
module tb_mux_bus_arbiter;

    typedef struct {
        string      tag;
        logic [7:0] g;
        logic [2:0] s;
        logic       v;
        logic [7:0] c;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    mux_bus_arbiter_if bus();

    mux_bus_arbiter #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [7:0] g, input logic [2:0] s,
                        input logic v, input logic [7:0] c);
        exp_t e;
        e.tag = tag; e.g = g; e.s = s; e.v = v; e.c = c;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [19:0] obs, req_v;
        logic        inv;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e     = sb.pop_front();
        obs   = {bus.grant, bus.selCode, bus.busValid, bus.busyCnt};
        req_v = {e.g, e.s, e.v, e.c};
        assert (obs === req_v) else begin
            failures++;
            $error("FAIL %s observed grant=%h sel=%0d valid=%b cnt=%0d expected grant=%h sel=%0d valid=%b cnt=%0d",
                   e.tag, bus.grant, bus.selCode, bus.busValid, bus.busyCnt, e.g, e.s, e.v, e.c);
        end
        checks++;
        inv = $onehot0(bus.grant) && (bus.busValid == (bus.grant != 8'h00));
        assert (inv === 1'b1) else begin
            failures++;
            $error("FAIL %s_invariant observed grant=%h valid=%b expected onehot0 grant matching valid",
                   e.tag, bus.grant, bus.busValid);
        end
    endtask

    task automatic step(input logic [7:0] r, input logic en, input logic [7:0] g,
                        input logic [2:0] s, input logic v, input logic [7:0] c,
                        input string tag);
        bus.req   = r;
        bus.arbEn = en;
        push(tag, g, s, v, c);
        @(posedge clk);
        #1;
        check_out();
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        push(tag, 8'h00, 3'd0, 1'b0, 8'd0);
        check_out();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] own;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        bus.req   = 8'h00;
        bus.arbEn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        push("reset", 8'h00, 3'd0, 1'b0, 8'd0);
        check_out();
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short request from port 0: two beats, turnaround, idle.
        step(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'd0, "short_g0");
        step(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'd1, "short_g1");
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "short_turn");
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "short_idle");

        // Persistent single requester: 4 beats, 1 turn, repeat.
        for (int i = 0; i < 12; i++) begin
            if (i % 5 < 4)
                step(8'h01, 1'b1, 8'h01, 3'd0, 1'b1, 8'(i % 5), $sformatf("burst_%0d", i));
            else
                step(8'h01, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, $sformatf("burst_%0d", i));
        end
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "burst_rel_turn");
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "burst_rel_idle");

        // Ports 0 and 7 alternate from reset.
        do_reset("reset_pair");
        for (int i = 0; i < 20; i++) begin
            own = ((i / 5) % 2 == 1) ? 3'd7 : 3'd0;
            if (i % 5 < 4)
                step(8'h81, 1'b1, 8'd1 << own, own, 1'b1, 8'(i % 5), $sformatf("pair_%0d", i));
            else
                step(8'h81, 1'b1, 8'h00, own, 1'b0, 8'd0, $sformatf("pair_%0d", i));
        end
        step(8'h00, 1'b1, 8'h00, 3'd7, 1'b0, 8'd0, "pair_idle");

        // All ports requesting: owners 0..7 then 0 again.
        for (int i = 0; i < 45; i++) begin
            own = 3'((i / 5) % 8);
            if (i % 5 < 4)
                step(8'hFF, 1'b1, 8'd1 << own, own, 1'b1, 8'(i % 5), $sformatf("all_%0d", i));
            else
                step(8'hFF, 1'b1, 8'h00, own, 1'b0, 8'd0, $sformatf("all_%0d", i));
        end
        step(8'h00, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "all_idle");

        // arbEn gating: blocks new grants only, never cuts a running burst.
        step(8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0, "en_block0");
        step(8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0, "en_block1");
        step(8'h04, 1'b0, 8'h00, 3'd0, 1'b0, 8'd0, "en_block2");
        step(8'h04, 1'b1, 8'h04, 3'd2, 1'b1, 8'd0, "en_grant0");
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd1, "en_grant1");
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd2, "en_grant2");
        step(8'h04, 1'b0, 8'h04, 3'd2, 1'b1, 8'd3, "en_grant3");
        step(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 8'd0, "en_turn");
        step(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 8'd0, "en_idle0");
        step(8'h04, 1'b0, 8'h00, 3'd2, 1'b0, 8'd0, "en_idle1");
        step(8'h00, 1'b1, 8'h00, 3'd2, 1'b0, 8'd0, "en_idle2");

        // Owner hands over: release and new request in the same cycle.
        step(8'h08, 1'b1, 8'h08, 3'd3, 1'b1, 8'd0, "hand_g3");
        step(8'h10, 1'b1, 8'h00, 3'd3, 1'b0, 8'd0, "hand_turn");
        step(8'h10, 1'b1, 8'h10, 3'd4, 1'b1, 8'd0, "hand_g4");
        step(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 8'd0, "hand_rel");
        step(8'h00, 1'b1, 8'h00, 3'd4, 1'b0, 8'd0, "hand_idle");

        // Reset in the middle of a grant to port 5.
        step(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'd0, "mid_g5a");
        step(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'd1, "mid_g5b");
        bus.req = 8'h21;
        do_reset("mid_reset");
        // do_reset already passed one edge with reset released; req=21 was seen.
        push("post_reset_g0", 8'h01, 3'd0, 1'b1, 8'd0);
        check_out();
        step(8'h21, 1'b1, 8'h01, 3'd0, 1'b1, 8'd1, "post_reset_g0b");
        step(8'h20, 1'b1, 8'h00, 3'd0, 1'b0, 8'd0, "post_reset_turn");
        step(8'h20, 1'b1, 8'h20, 3'd5, 1'b1, 8'd0, "post_reset_g5");
        step(8'h00, 1'b1, 8'h00, 3'd5, 1'b0, 8'd0, "post_reset_rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares the 8-input, 3-bit-coded datapath select mux among 8 requesters.
- Each requester owns one mux input slot. The arbiter drives the mux select code and a one-hot grant to the requesters.
- Sits between requesting units (ALU, memory, immediate, register paths) and the select port of the shared mux.
- Enforces a bounded burst length and one turnaround cycle between owners.

Parameters:
- MAX_BURST, 4: maximum consecutive GRANT cycles per ownership. Legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- arbEn  input  1  1 = new grants allowed. 0 blocks new grants only; an in-progress grant runs to completion.
- req  input  8  request vector; bit i = requester i (mux input code i)
- grant  output  8  one-hot grant, registered
- selCode  output  3  select code to the mux = current or last owner index, registered
- busValid  output  1  1 while a grant is active (selected data valid), registered
- busyCnt  output  8  beats used in the current ownership, 0-based, registered

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE, grant=0, selCode=3'b000, busValid=0, busyCnt=0.
  - lastOwner=7, so requester 0 has top priority first.
- FSM states: IDLE, GRANT, TURN.
- Winner selection (combinational):
  - Scan from (lastOwner+1) mod 8 upward, circularly; the first set req bit wins.
  - lastOwner itself is lowest priority.
- IDLE:
  - If arbEn=1 and req!=0: at the next edge go GRANT with winner w. grant=1<<w, selCode=w, busValid=1, busyCnt=0, lastOwner=w.
  - Otherwise stay in IDLE.
- Latency: req sampled high at edge N -> grant visible after edge N (1-cycle registered latency).
- GRANT, at each edge with owner o:
  - req[o]=0 -> TURN. Early release; the beat in which req dropped is not granted further.
  - else if busyCnt==MAX_BURST-1 -> TURN (burst limit).
  - else stay in GRANT, busyCnt+1.
  - arbEn has no effect in GRANT.
- TURN (exactly 1 cycle):
  - grant=0, busValid=0, busyCnt=0, selCode holds o (mux input stays stable).
  - At the next edge, same rule as IDLE: new winner -> GRANT, else IDLE.
- Grant timing:
  - Minimum ownership is 1 cycle, maximum is MAX_BURST cycles.
  - With continuous requests from all ports, period per owner = MAX_BURST+1 cycles.
- Invariants:
  - grant is always zero or one-hot.
  - busValid == (grant!=0).
  - selCode changes only on entry to GRANT.
- Simultaneous events:
  - Owner drops req in the same cycle another raises it: TURN first, then the new owner.
  - Single persistent requester: re-granted after every TURN.
  - Requests asserted during TURN are considered at TURN exit.
- Reset mid-GRANT: outputs clear immediately (asynchronous); lastOwner returns to 7.
- req bits not owned are ignored during GRANT. No queuing; requesters must hold req until granted.
- busyCnt is 8 bits; MAX_BURST=1 yields single-beat grants (busyCnt stays 0).

Test Plan:
- Reset, then req=8'h01 held 2 cycles, MAX_BURST=4 -> grant=8'h01 and selCode=0 one cycle after sampling; 2 grant cycles; 1 TURN with selCode=0, busValid=0; then IDLE.
- req=8'h01 held 12 cycles, MAX_BURST=4 -> repeating pattern: 4 GRANT cycles (busyCnt 0..3), 1 TURN, re-grant of 0; grant never exceeds 4 consecutive cycles.
- req=8'h81 held, from reset -> owner sequence 0,7,0,7; each period = 5 cycles; selCode alternates 0/7.
- req=8'hFF held -> owner sequence 0,1,2,...,7,0; never two consecutive grants to the same port while others request.
- arbEn=0 with req=8'h04 -> grant stays 0. arbEn raised -> grant=8'h04 next cycle. Dropping arbEn mid-grant -> burst still completes 4 cycles, then no new grant.
- rst_n pulsed low during GRANT to port 5 -> grant=0, busValid=0, selCode=0 immediately. After release with req=8'h21 -> port 0 granted first.
